slow_link_scheduler: RTL and testbench

Arbiter and flow controller placed in front of the slow transmitter. It shares the transmitter's input FIFO between the time-frame source and several housekeeping/status requesters. It tracks FIFO occupancy with a credit model so that no word is ever pushed into a full FIFO. It emits exactly one push pulse per accepted word, with the payload aligned to that pulse.

---
 rtl/slow_link_scheduler_if.sv | 36 +++
 rtl/slow_link_scheduler.sv | 159 +++++++++++++++
 tb/tb_slow_link_scheduler.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/slow_link_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : slow_link_scheduler_if
// Description : Request/grant bundle between the requesters, the scheduler
//               and the slow transmitter's input FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface slow_link_scheduler_if #(
  parameter int N_REQ     = 4,
  parameter int PAYLOAD_W = 8,
  parameter int OCC_W     = 5
) ();

  logic [N_REQ-1:0]           req_valid_i;
  logic [N_REQ*PAYLOAD_W-1:0] req_payload_i;
  logic [N_REQ-1:0]           req_ready_o;
  logic                       tx_idle_i;
  logic [PAYLOAD_W-1:0]       payload_o;
  logic                       frame_tick_o;
  logic [OCC_W-1:0]           occupancy_o;
  logic                       overflow_o;

  // Requester / transmitter side
  modport master (
    output req_valid_i, req_payload_i, tx_idle_i,
    input  req_ready_o, payload_o, frame_tick_o, occupancy_o, overflow_o
  );

  // Scheduler side
  modport slave (
    input  req_valid_i, req_payload_i, tx_idle_i,
    output req_ready_o, payload_o, frame_tick_o, occupancy_o, overflow_o
  );

endinterface
`default_nettype wire

// File: rtl/slow_link_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : slow_link_scheduler
// Description : Arbiter and credit-based flow controller in front of the slow
//               transmitter FIFO. Channel 0 (frame source) has priority with
//               a burst cap; channels 1..N_REQ-1 share round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module slow_link_scheduler #(
  parameter int N_REQ         = 4,
  parameter int PAYLOAD_W     = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int CREDIT_MARGIN = 2,
  parameter int WORD_PERIOD   = 800,
  parameter int MAX_BURST     = 8
) (
  input  wire logic            clk,
  input  wire logic            reset,
  slow_link_scheduler_if.slave bus
);

  localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W   = $clog2(N_REQ);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int TIMER_W = $clog2(WORD_PERIOD);

  localparam logic [OCC_W-1:0]   c_PUSH_LIMIT = OCC_W'(FIFO_DEPTH - CREDIT_MARGIN);
  localparam logic [OCC_W-1:0]   c_DEPTH      = OCC_W'(FIFO_DEPTH);
  localparam logic [BURST_W-1:0] c_MAX_BURST  = BURST_W'(MAX_BURST);
  localparam logic [TIMER_W-1:0] c_TIMER_LAST = TIMER_W'(WORD_PERIOD - 1);

  // State
  logic [OCC_W-1:0]     r_occ;
  logic [TIMER_W-1:0]   r_timer;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [BURST_W-1:0]   r_burst;
  logic                 r_acc_d1;
  logic                 r_acc_d2;
  logic                 r_tick;
  logic [PAYLOAD_W-1:0] r_payload;
  logic                 r_overflow;

  // Arbitration
  logic                 w_can_push;
  logic                 w_others;
  logic                 w_burst_block;
  logic                 w_rr_found;
  logic [PTR_W-1:0]     w_rr_idx;
  int                   w_dist;
  int                   w_best;
  logic                 w_gnt_ch0;
  logic                 w_gnt_rr;
  logic                 w_accept;
  logic [N_REQ-1:0]     w_grant;
  logic [PAYLOAD_W-1:0] w_sel_payload;

  // Credit model
  logic                 w_drain;
  logic                 w_resync;

  // Same-cycle grant: channel 0 first unless its burst is exhausted while
  // others wait; otherwise the nearest valid channel at or after rr_ptr.
  always_comb begin
    w_can_push    = (r_occ < c_PUSH_LIMIT) && !reset;
    w_others      = |bus.req_valid_i[N_REQ-1:1];
    w_burst_block = (r_burst == c_MAX_BURST) && w_others;
    w_rr_found    = 1'b0;
    w_rr_idx      = '0;
    w_dist        = 0;
    w_best        = N_REQ;
    for (int k = 1; k < N_REQ; k++) begin
      if (bus.req_valid_i[k]) begin
        // Distance from the pointer, wrapping N_REQ-1 back to 1
        if (k >= int'(r_rr_ptr)) w_dist = k - int'(r_rr_ptr);
        else                     w_dist = k - int'(r_rr_ptr) + (N_REQ - 1);
        if (w_dist < w_best) begin
          w_best     = w_dist;
          w_rr_idx   = PTR_W'(k);
          w_rr_found = 1'b1;
        end
      end
    end
    w_gnt_ch0 = w_can_push && bus.req_valid_i[0] && !w_burst_block;
    w_gnt_rr  = w_can_push && !w_gnt_ch0 && w_rr_found;
    w_accept  = w_gnt_ch0 || w_gnt_rr;
    w_grant    = '0;
    w_grant[0] = w_gnt_ch0;
    w_sel_payload = bus.req_payload_i[PAYLOAD_W-1:0];
    for (int k = 1; k < N_REQ; k++) begin
      w_grant[k] = w_gnt_rr && (w_rr_idx == PTR_W'(k));
      if (w_grant[k]) w_sel_payload = bus.req_payload_i[k*PAYLOAD_W +: PAYLOAD_W];
    end
    w_drain  = (r_occ != '0) && (r_timer == c_TIMER_LAST);
    // Transmitter idle and nothing pushed recently: the real FIFO is empty
    w_resync = bus.tx_idle_i && !r_acc_d1 && !r_acc_d2;
  end

  // Round-robin pointer and channel-0 burst counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= PTR_W'(1);
      r_burst  <= '0;
    end else begin
      if (w_gnt_rr) begin
        r_rr_ptr <= (w_rr_idx == PTR_W'(N_REQ - 1)) ? PTR_W'(1) : w_rr_idx + PTR_W'(1);
        r_burst  <= '0;
      end else if (w_gnt_ch0 && w_others) begin
        if (r_burst != c_MAX_BURST) r_burst <= r_burst + BURST_W'(1);
      end else if (!w_others) begin
        r_burst <= '0;
      end
    end
  end

  // FIFO occupancy model with drain timer and idle resync
  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ    <= '0;
      r_timer  <= '0;
      r_acc_d1 <= 1'b0;
      r_acc_d2 <= 1'b0;
    end else begin
      r_acc_d1 <= w_accept;
      r_acc_d2 <= r_acc_d1;
      if (w_resync) begin
        // A push in the resync cycle still lands in the now-empty FIFO
        r_occ   <= w_accept ? OCC_W'(1) : '0;
        r_timer <= '0;
      end else begin
        if (w_accept && !w_drain)      r_occ <= r_occ + OCC_W'(1);
        else if (!w_accept && w_drain) r_occ <= r_occ - OCC_W'(1);
        if (r_occ == '0 || r_timer == c_TIMER_LAST) r_timer <= '0;
        else                                         r_timer <= r_timer + TIMER_W'(1);
      end
    end
  end

  // Registered push strobe, payload and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick     <= 1'b0;
      r_payload  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_tick <= w_accept;
      if (w_accept) r_payload <= w_sel_payload;
      if (w_accept && r_occ == c_DEPTH) r_overflow <= 1'b1;
    end
  end

  assign bus.req_ready_o  = w_grant;
  // A tick already registered is withheld if reset arrives in its cycle
  assign bus.frame_tick_o = r_tick && !reset;
  assign bus.payload_o    = r_payload;
  assign bus.occupancy_o  = r_occ;
  assign bus.overflow_o   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_slow_link_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_slow_link_scheduler
// Description : Directed and randomized bench for slow_link_scheduler with a
//               cycle-level reference model of the arbitration and credits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slow_link_scheduler;

  localparam int N      = 4;
  localparam int PW     = 8;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 2;
  localparam int WP     = 800;
  localparam int MB     = 8;
  localparam int OW     = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  slow_link_scheduler_if #(.N_REQ(N), .PAYLOAD_W(PW), .OCC_W(OW)) bus ();

  slow_link_scheduler #(
    .N_REQ(N), .PAYLOAD_W(PW), .FIFO_DEPTH(DEPTH), .CREDIT_MARGIN(MARGIN),
    .WORD_PERIOD(WP), .MAX_BURST(MB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Requester-side stimulus state
  logic [N-1:0]  valid;
  logic [PW-1:0] pl [N];
  logic          tx_idle;

  // Reference model state
  int            m_occ, m_timer, m_rr, m_burst;
  bit            m_a1, m_a2, m_tick, m_ovf;
  logic [PW-1:0] m_pay;

  // Observations from the latest cycle
  int            last_grant;
  int            accepts;
  logic [N-1:0]  obs_ready;
  logic          obs_tick;
  logic [PW-1:0] obs_pay;
  logic [OW-1:0] obs_occ;
  logic          obs_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_occ = 0; m_timer = 0; m_rr = 1; m_burst = 0;
    m_a1 = 0; m_a2 = 0; m_tick = 0; m_ovf = 0; m_pay = '0;
  endfunction

  // Which channel the rules say is granted this cycle (-1: none)
  function automatic int model_grant();
    bit others;
    others = |valid[N-1:1];
    if (reset || m_occ >= DEPTH - MARGIN) return -1;
    if (valid[0] && !(m_burst == MB && others)) return 0;
    for (int off = 0; off < N - 1; off++) begin
      int k;
      k = 1 + ((m_rr - 1 + off) % (N - 1));
      if (valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_update(input int g);
    bit acc, drain, resync, others;
    int old;
    if (reset) begin
      model_reset();
      return;
    end
    acc    = (g >= 0);
    others = |valid[N-1:1];
    drain  = (m_occ > 0) && (m_timer == WP - 1);
    resync = tx_idle && !m_a1 && !m_a2;
    if (acc && m_occ == DEPTH) m_ovf = 1;
    m_tick = acc;
    if (acc) m_pay = pl[g];
    if (g >= 1) begin
      m_rr    = (g == N - 1) ? 1 : g + 1;
      m_burst = 0;
    end else if (g == 0 && others) begin
      m_burst = (m_burst < MB) ? m_burst + 1 : MB;
    end else if (!others) begin
      m_burst = 0;
    end
    old = m_occ;
    if (resync) begin
      m_occ   = acc ? 1 : 0;
      m_timer = 0;
    end else begin
      m_occ   = m_occ + int'(acc) - int'(drain);
      m_timer = (old == 0 || m_timer == WP - 1) ? 0 : m_timer + 1;
    end
    m_a2 = m_a1;
    m_a1 = acc;
  endtask

  // One clock: drive, sample at negedge against the model, advance at posedge
  task automatic cycle();
    int g;
    logic [N-1:0] exp_ready;
    bus.req_valid_i = valid;
    for (int i = 0; i < N; i++) bus.req_payload_i[i*PW +: PW] = pl[i];
    bus.tx_idle_i = tx_idle;
    @(negedge clk);
    g = model_grant();
    exp_ready = (g < 0) ? '0 : (N'(1) << g);
    obs_ready = bus.req_ready_o;
    obs_tick  = bus.frame_tick_o;
    obs_pay   = bus.payload_o;
    obs_occ   = bus.occupancy_o;
    obs_ovf   = bus.overflow_o;
    check("ready",     32'(obs_ready), 32'(exp_ready));
    check("tick",      32'(obs_tick),  32'(m_tick && !reset));
    check("payload",   32'(obs_pay),   32'(m_pay));
    check("occupancy", 32'(obs_occ),   32'(m_occ));
    check("overflow",  32'(obs_ovf),   32'(m_ovf));
    @(posedge clk);
    model_update(g);
    last_grant = g;
    if (g >= 0) begin
      accepts++;
      valid[g] = 1'b0;
    end
    #1;
  endtask

  initial begin
    valid   = '0;
    tx_idle = 1'b0;
    for (int i = 0; i < N; i++) pl[i] = '0;
    bus.req_valid_i   = '0;
    bus.req_payload_i = '0;
    bus.tx_idle_i     = 1'b0;
    model_reset();
    accepts    = 0;
    last_grant = -1;

    // Reset
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    reset = 1'b0;
    cycle();
    check("rst_ready", 32'(obs_ready), 32'h0);
    check("rst_occ",   32'(obs_occ),   32'h0);
    check("rst_pay",   32'(obs_pay),   32'h0);

    // Single channel-0 word
    valid[0] = 1'b1; pl[0] = 8'hA5;
    cycle();
    check("t1_ready", 32'(obs_ready), 32'h1);
    cycle();
    check("t1_tick", 32'(obs_tick), 32'h1);
    check("t1_pay",  32'(obs_pay),  32'hA5);
    check("t1_occ",  32'(obs_occ),  32'h1);

    // Fill to 5, then idle transmitter resyncs the model
    repeat (4) begin
      valid[0] = 1'b1; pl[0] = 8'($urandom);
      cycle();
    end
    tx_idle = 1'b1;
    cycle();
    check("rs_occ5", 32'(obs_occ), 32'd5);
    repeat (3) cycle();
    check("rs_occ0", 32'(obs_occ), 32'd0);

    // Round robin among channels 1..3
    tx_idle = 1'b0;
    for (int i = 0; i < 12; i++) begin
      for (int k = 1; k < N; k++)
        if (!valid[k]) begin valid[k] = 1'b1; pl[k] = 8'($urandom); end
      cycle();
      check("rr_grant", 32'(last_grant), 32'(1 + i % 3));
    end
    valid = '0; tx_idle = 1'b1;
    repeat (4) cycle();

    // All channels busy: eight channel-0 grants then one round-robin grant
    tx_idle = 1'b0;
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < N; k++)
        if (!valid[k]) begin valid[k] = 1'b1; pl[k] = 8'($urandom); end
      cycle();
      check("burst_grant", 32'(last_grant), (i == 8) ? 32'd1 : 32'd0);
    end
    valid = '0; tx_idle = 1'b1;
    repeat (4) cycle();
    check("burst_resync", 32'(obs_occ), 32'd0);

    // Credit limit and drain
    tx_idle = 1'b0;
    accepts = 0;
    for (int i = 0; i < 820; i++) begin
      if (!valid[0]) begin valid[0] = 1'b1; pl[0] = 8'($urandom); end
      cycle();
      if (i == 19) begin
        check("lim_accepts", 32'(accepts),   32'd14);
        check("lim_ready",   32'(obs_ready), 32'h0);
        check("lim_occ",     32'(obs_occ),   32'd14);
      end
    end
    check("drain_accepts", 32'(accepts), 32'd15);
    check("drain_occ",     32'(obs_occ), 32'd14);
    check("drain_ovf",     32'(obs_ovf), 32'h0);

    // Reset right after an accept suppresses the tick
    valid = '0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    valid[0] = 1'b1; pl[0] = 8'h3C;
    cycle();
    check("mr_ready", 32'(obs_ready), 32'h1);
    reset = 1'b1;
    cycle();
    check("mr_tick", 32'(obs_tick), 32'h0);
    reset = 1'b0;
    cycle();
    check("mr_tick2", 32'(obs_tick), 32'h0);
    check("mr_pay",   32'(obs_pay),  32'h0);
    check("mr_occ",   32'(obs_occ),  32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 499) == 0);
      tx_idle = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < N; k++)
        if (!valid[k] && $urandom_range(0, 2) == 0) begin
          valid[k] = 1'b1;
          pl[k]    = 8'($urandom);
        end
      cycle();
    end
    reset = 1'b0;
    check("final_ovf", 32'(obs_ovf), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
